attack_checker: RTL and testbench

- Validates one player's attack switch vector before the top level latches it; also replaces the unused one-new-position input check.
- Synchronises raw switches and the submit button, waits for the switches to settle, then requires exactly one new attack bit with no previously-used bit cleared.
- On success it pulses ok, presents the new position one-hot and updates attack history and hit count. Its ok feeds the game FSM's OKA/OKB input.

---
 rtl/bs_pkg.sv | 17 +
 rtl/sync2.sv | 23 ++
 rtl/attack_checker.sv | 120 ++++++++++++
 tb/tb_attack_checker.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bs_pkg.sv
// Shared types for the attack checker: controller states and reject reason codes.
package bs_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CHECK,
    ACCEPT,
    REJECT,
    WAIT_REL
  } state_t;

  localparam logic [1:0] ERR_NONE_NEW = 2'b01;
  localparam logic [1:0] ERR_MULTI    = 2'b10;
  localparam logic [1:0] ERR_CLEARED  = 2'b11;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous inputs, clearable with the system reset.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/attack_checker.sv
// Validates a player's attack switches on each submit press: exactly one new
// position, no previously attacked position dropped; tracks history and hits.
module attack_checker
  import bs_pkg::*;
#(
  parameter int N             = 10,
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int CW            = 4
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic [N-1:0]  attack_in,
  input  logic          submit,
  input  logic [N-1:0]  ships,
  output logic [N-1:0]  history,
  output logic [N-1:0]  new_pos,
  output logic          ok,
  output logic          reject,
  output logic [1:0]    err_code,
  output logic          hit,
  output logic [CW-1:0] hit_count,
  output logic [CW-1:0] attack_count,
  output logic          busy
);

  // +1 keeps the counter at least one bit wide when STABLE_CYCLES is 1
  localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  state_t           state, state_nx;
  logic [N-1:0]     att_s, snap, diff, lost;
  logic             sub_s, sub_d, sub_rise;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       code;
  logic             good, hit_now;

  function automatic int popcount(input logic [N-1:0] v);
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(v[i]);
    return c;
  endfunction

  sync2 #(.W(N)) u_sync_att (.clk(clk), .clr_n(clr_n), .d(attack_in), .q(att_s));
  sync2 #(.W(1)) u_sync_sub (.clk(clk), .clr_n(clr_n), .d(submit),    .q(sub_s));

  assign sub_rise = sub_s & ~sub_d;

  // snap and history are frozen through CHECK/ACCEPT/REJECT, so the verdict
  // can be recomputed in whichever of those states needs it
  always_comb begin
    diff    = snap & ~history;
    lost    = history & ~snap;
    hit_now = |(diff & ships);
    good    = 1'b0;
    code    = ERR_NONE_NEW;
    if (lost != '0)              code = ERR_CLEARED;
    else if (popcount(diff) == 0) code = ERR_NONE_NEW;
    else if (popcount(diff) > 1)  code = ERR_MULTI;
    else                          good = 1'b1;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (sub_rise) state_nx = SETTLE;
      SETTLE:   if (att_s == snap && cnt == CNT_LAST) state_nx = CHECK;
      CHECK:    state_nx = good ? ACCEPT : REJECT;
      ACCEPT:   state_nx = WAIT_REL;
      REJECT:   state_nx = WAIT_REL;
      WAIT_REL: if (!sub_s) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state        <= IDLE;
      sub_d        <= 1'b0;
      cnt          <= '0;
      snap         <= '0;
      history      <= '0;
      new_pos      <= '0;
      err_code     <= '0;
      hit_count    <= '0;
      attack_count <= '0;
    end else begin
      state <= state_nx;
      sub_d <= sub_s;
      case (state)
        IDLE: if (sub_rise) begin
          cnt  <= '0;
          snap <= att_s;
        end
        SETTLE: begin
          if (att_s != snap) begin
            snap <= att_s;
            cnt  <= '0;
          end else if (cnt != CNT_LAST) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ACCEPT: begin
          new_pos <= diff;
          history <= history | diff;
          if (attack_count != '1) attack_count <= attack_count + CW'(1);
          if (hit_now && hit_count != '1) hit_count <= hit_count + CW'(1);
        end
        REJECT: err_code <= code;
        default: ;
      endcase
    end
  end

  // gated by clr_n so no pulse can coincide with a reset cycle
  assign ok     = clr_n && (state == ACCEPT);
  assign reject = clr_n && (state == REJECT);
  assign hit    = ok && hit_now;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_attack_checker.sv
// Directed bench for attack_checker (N=10, STABLE_CYCLES=4, CW=4) plus a
// 16-wide instance to reach counter saturation.
module tb_attack_checker;

  localparam int N  = 10;
  localparam int SC = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          clr_n, submit;
  logic [N-1:0]  attack_in, ships, history, new_pos;
  logic          ok, reject, hit, busy;
  logic [1:0]    err_code;
  logic [CW-1:0] hit_count, attack_count;

  logic [15:0]   attack16, ships16, history16, new_pos16;
  logic          ok16, reject16, hit16, busy16;
  logic [1:0]    err_code16;
  logic [CW-1:0] hit_count16, attack_count16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  attack_checker #(.N(N), .STABLE_CYCLES(SC), .CW(CW)) dut (
    .clk(clk), .clr_n(clr_n), .attack_in(attack_in), .submit(submit), .ships(ships),
    .history(history), .new_pos(new_pos), .ok(ok), .reject(reject), .err_code(err_code),
    .hit(hit), .hit_count(hit_count), .attack_count(attack_count), .busy(busy)
  );

  attack_checker #(.N(16), .STABLE_CYCLES(SC), .CW(CW)) dut16 (
    .clk(clk), .clr_n(clr_n), .attack_in(attack16), .submit(submit), .ships(ships16),
    .history(history16), .new_pos(new_pos16), .ok(ok16), .reject(reject16),
    .err_code(err_code16), .hit(hit16), .hit_count(hit_count16),
    .attack_count(attack_count16), .busy(busy16)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive one submit press and report the first decision and its latency in
  // clocks from the raw submit edge (-1 if none came).
  task automatic press(input logic [N-1:0] att, input logic [N-1:0] shp, output int lat,
                       output logic got_ok, output logic got_rej, output logic got_hit);
    attack_in = att;
    ships     = shp;
    submit    = 1'b1;
    lat = -1; got_ok = 1'b0; got_rej = 1'b0; got_hit = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (ok || reject) begin
        lat = i; got_ok = ok; got_rej = reject; got_hit = hit;
        break;
      end
    end
    submit = 1'b0;
    for (int i = 0; i < 10 && busy; i++) step();
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    step();
    step();
    clr_n = 1'b1;
    checks++;
    if ({history, new_pos, ok, reject, err_code, hit, hit_count, attack_count, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: hist=%h pos=%h ok=%b rej=%b err=%b hit=%b hc=%0d ac=%0d busy=%b, want all 0",
               history, new_pos, ok, reject, err_code, hit, hit_count, attack_count, busy);
    end
    checks++;
    if ({history16, hit_count16, attack_count16, busy16} !== '0) begin
      errors++;
      $display("FAIL reset_outputs16: hist=%h hc=%0d ac=%0d busy=%b, want all 0",
               history16, hit_count16, attack_count16, busy16);
    end
  endtask

  task automatic test_accept_hit();
    int lat; logic o, r, h;
    press(10'h004, 10'h004, lat, o, r, h);
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL accept_latency: got %0d want 8", lat); end
    checks++;
    if ({o, r, h} !== 3'b101) begin errors++; $display("FAIL accept_hit_pulses: ok/rej/hit got %b want 101", {o, r, h}); end
    checks++;
    if ({new_pos, history} !== {10'h004, 10'h004}) begin
      errors++; $display("FAIL accept_hit_pos: new_pos=%h hist=%h want 004 004", new_pos, history);
    end
    checks++;
    if ({hit_count, attack_count} !== {4'd1, 4'd1}) begin
      errors++; $display("FAIL accept_hit_counts: hc=%0d ac=%0d want 1 1", hit_count, attack_count);
    end
  endtask

  task automatic test_accept_miss();
    int lat; logic o, r, h;
    press(10'h00C, 10'h000, lat, o, r, h);
    checks++;
    if ({o, r, h} !== 3'b100) begin errors++; $display("FAIL accept_miss_pulses: ok/rej/hit got %b want 100", {o, r, h}); end
    checks++;
    if ({new_pos, history} !== {10'h008, 10'h00C}) begin
      errors++; $display("FAIL accept_miss_pos: new_pos=%h hist=%h want 008 00c", new_pos, history);
    end
    checks++;
    if ({hit_count, attack_count} !== {4'd1, 4'd2}) begin
      errors++; $display("FAIL accept_miss_counts: hc=%0d ac=%0d want 1 2", hit_count, attack_count);
    end
  endtask

  task automatic test_reject();
    int lat; logic o, r, h;
    press(10'h03C, 10'h000, lat, o, r, h);
    checks++;
    if ({lat, o, r, h} !== {32'd8, 3'b010}) begin
      errors++; $display("FAIL reject_multi_pulse: lat=%0d ok/rej/hit=%b want 8 010", lat, {o, r, h});
    end
    checks++;
    if ({err_code, history, new_pos} !== {2'b10, 10'h00C, 10'h008}) begin
      errors++; $display("FAIL reject_multi_state: err=%b hist=%h pos=%h want 10 00c 008", err_code, history, new_pos);
    end
    press(10'h00C, 10'h000, lat, o, r, h);
    checks++;
    if ({r, err_code} !== {1'b1, 2'b01}) begin
      errors++; $display("FAIL reject_none_new: rej=%b err=%b want 1 01", r, err_code);
    end
    press(10'h018, 10'h000, lat, o, r, h);
    checks++;
    if ({r, err_code, history} !== {1'b1, 2'b11, 10'h00C}) begin
      errors++; $display("FAIL reject_cleared: rej=%b err=%b hist=%h want 1 11 00c", r, err_code, history);
    end
    checks++;
    if (attack_count !== 4'd2) begin errors++; $display("FAIL reject_count: ac=%0d want 2", attack_count); end
  endtask

  task automatic test_settle_hold();
    int early = 0, oks = 0, rejs = 0;
    logic [N-1:0] pos_at_ok = '0;
    submit = 1'b1;
    for (int i = 0; i < 12; i++) begin
      attack_in = ((i / 2) % 2 == 1) ? 10'h03C : 10'h01C;
      step();
      if (ok || reject) early++;
    end
    attack_in = 10'h01C;
    for (int i = 0; i < 50; i++) begin
      step();
      if (ok) begin oks++; pos_at_ok = new_pos; end
      if (reject) rejs++;
    end
    submit = 1'b0;
    for (int i = 0; i < 10 && busy; i++) step();
    checks++;
    if (early !== 0) begin errors++; $display("FAIL settle_no_early: decisions=%0d want 0", early); end
    checks++;
    if ({oks, rejs} !== {32'd1, 32'd0}) begin
      errors++; $display("FAIL hold_single_ok: oks=%0d rejects=%0d want 1 0", oks, rejs);
    end
    checks++;
    if ({new_pos, history} !== {10'h010, 10'h01C}) begin
      errors++; $display("FAIL settle_pos: new_pos=%h hist=%h want 010 01c", new_pos, history);
    end
    checks++;
    if ({err_code, attack_count, busy} !== {2'b11, 4'd3, 1'b0}) begin
      errors++; $display("FAIL settle_err_kept: err=%b ac=%0d busy=%b want 11 3 0", err_code, attack_count, busy);
    end
  endtask

  task automatic test_reset_mid();
    attack_in = 10'h020;
    submit    = 1'b1;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: busy=%b want 1", busy); end
    clr_n = 1'b0;
    step();
    clr_n  = 1'b1;
    submit = 1'b0;
    checks++;
    if ({history, new_pos, ok, reject, err_code, hit, hit_count, attack_count, busy} !== '0) begin
      errors++;
      $display("FAIL mid_reset: hist=%h pos=%h ok=%b rej=%b err=%b hit=%b hc=%0d ac=%0d busy=%b, want all 0",
               history, new_pos, ok, reject, err_code, hit, hit_count, attack_count, busy);
    end
  endtask

  task automatic test_saturate();
    int oks16 = 0, oks = 0, rejs = 0;
    attack16 = '0;
    ships16  = 16'hFFFF;
    ships    = 10'h3FF;
    for (int p = 0; p < 16; p++) begin
      attack16[p] = 1'b1;
      attack_in   = attack16[N-1:0];
      submit      = 1'b1;
      for (int i = 0; i < 30; i++) begin
        step();
        if (ok16 || reject16) begin
          if (ok16) oks16++;
          if (ok)     oks++;
          if (reject) rejs++;
          break;
        end
      end
      submit = 1'b0;
      for (int i = 0; i < 10 && (busy || busy16); i++) step();
    end
    checks++;
    if ({oks16, hit_count16, attack_count16, history16} !== {32'd16, 4'd15, 4'd15, 16'hFFFF}) begin
      errors++; $display("FAIL saturate16: oks=%0d hc=%0d ac=%0d hist=%h want 16 15 15 ffff",
                         oks16, hit_count16, attack_count16, history16);
    end
    checks++;
    if ({oks, rejs} !== {32'd10, 32'd6}) begin
      errors++; $display("FAIL full_history_decisions: oks=%0d rejects=%0d want 10 6", oks, rejs);
    end
    checks++;
    if ({history, err_code, hit_count, attack_count} !== {10'h3FF, 2'b01, 4'd10, 4'd10}) begin
      errors++; $display("FAIL full_history_state: hist=%h err=%b hc=%0d ac=%0d want 3ff 01 10 10",
                         history, err_code, hit_count, attack_count);
    end
  endtask

  initial begin
    clr_n = 1'b0; submit = 1'b0; attack_in = '0; ships = '0;
    attack16 = '0; ships16 = '0;
    @(negedge clk);
    test_reset();
    test_accept_hit();
    test_accept_miss();
    test_reject();
    test_settle_hold();
    test_reset_mid();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
